// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges the ALU result path and a FIFO-buffered MEM result path
// onto the single register-file write port, with starvation forcing and a retire counter.
module writeback_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          alu_valid,
    output logic                          alu_ready,
    input  logic [ADDR_WIDTH-1:0]         alu_rd,
    input  logic [DATA_WIDTH-1:0]         alu_data,
    input  logic                          mem_valid,
    output logic                          mem_ready,
    input  logic [ADDR_WIDTH-1:0]         mem_rd,
    input  logic [DATA_WIDTH-1:0]         mem_data,
    output logic [ADDR_WIDTH-1:0]         write_address,
    output logic [DATA_WIDTH-1:0]         write_data,
    output logic                          write_enable,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [63:0]                   retire_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [STV_W-1:0] LIMIT_C = STV_W'(STARVE_LIMIT);

    logic [ADDR_WIDTH-1:0] fifo_rd_mem   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [STV_W-1:0]      starve_q;

    logic                  fifo_empty;
    logic                  starved;
    logic                  mem_hs;
    logic                  push;
    logic                  pop;
    logic                  vld_p0;
    logic [ADDR_WIDTH-1:0] rd_p0;
    logic [DATA_WIDTH-1:0] data_p0;

    assign fifo_empty = (fifo_count == '0);
    assign starved    = (starve_q == LIMIT_C);
    assign mem_ready  = (fifo_count != DEPTH_C);
    assign alu_ready  = !starved;
    assign mem_hs     = mem_valid && mem_ready;

    // Stage p0: pick at most one result to commit this cycle.
    always_comb begin
        vld_p0  = 1'b0;
        rd_p0   = '0;
        data_p0 = '0;
        push    = 1'b0;
        pop     = 1'b0;
        if (starved) begin
            vld_p0  = 1'b1;
            rd_p0   = fifo_rd_mem[rd_ptr_q];
            data_p0 = fifo_data_mem[rd_ptr_q];
            pop     = 1'b1;
            push    = mem_hs;
        end else if (alu_valid) begin
            vld_p0  = 1'b1;
            rd_p0   = alu_rd;
            data_p0 = alu_data;
            push    = mem_hs;
        end else if (!fifo_empty) begin
            vld_p0  = 1'b1;
            rd_p0   = fifo_rd_mem[rd_ptr_q];
            data_p0 = fifo_data_mem[rd_ptr_q];
            pop     = 1'b1;
            push    = mem_hs;
        end else if (mem_hs) begin
            // Nothing is queued ahead of it, so the MEM result goes straight through.
            vld_p0  = 1'b1;
            rd_p0   = mem_rd;
            data_p0 = mem_data;
        end
    end

    // FIFO payload storage carries no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_mem[wr_ptr_q]   <= mem_rd;
            fifo_data_mem[wr_ptr_q] <= mem_data;
        end
    end

    // Stage p1: registered write port and bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_count    <= '0;
            starve_q      <= '0;
            write_enable  <= 1'b0;
            write_address <= '0;
            write_data    <= '0;
            retire_count  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            fifo_count <= fifo_count + {{(CNT_W-1){1'b0}}, push}
                                     - {{(CNT_W-1){1'b0}}, pop};

            if (fifo_empty || pop) begin
                starve_q <= '0;
            end else if (!starved) begin
                starve_q <= starve_q + STV_W'(1);
            end

            write_enable <= vld_p0 && (rd_p0 != '0);
            if (vld_p0) begin
                write_address <= rd_p0;
                write_data    <= data_p0;
            end
            retire_count <= retire_count + {63'b0, vld_p0};
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the commit rules.
module tb_writeback_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          alu_valid = 1'b0;
    logic          alu_ready;
    logic [AW-1:0] alu_rd = '0;
    logic [DW-1:0] alu_data = '0;
    logic          mem_valid = 1'b0;
    logic          mem_ready;
    logic [AW-1:0] mem_rd = '0;
    logic [DW-1:0] mem_data = '0;
    logic [AW-1:0] write_address;
    logic [DW-1:0] write_data;
    logic          write_enable;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [63:0]   retire_count;

    always #5 clk = ~clk;

    writeback_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .write_address(write_address), .write_data(write_data), .write_enable(write_enable),
        .fifo_count(fifo_count), .retire_count(retire_count)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: MEM buffer as a queue, starvation as a plain integer.
    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          mq[$];
    int            m_starve;
    logic [63:0]   m_retire;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;

    function automatic void model_reset();
        mq.delete();
        m_starve = 0;
        m_retire = '0;
        m_we     = 1'b0;
        m_addr   = '0;
        m_data   = '0;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        #1;
        check_val("rst_we", write_enable, 0);
        check_val("rst_cnt", fifo_count, 0);
        check_val("rst_retire", retire_count, 0);
        check_val("rst_addr", write_address, 0);
        check_val("rst_data", write_data, 0);
        check_val("rst_alu_ready", alu_ready, 1);
        check_val("rst_mem_ready", mem_ready, 1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic cycle(input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] adat,
                         input logic mv, input logic [AW-1:0] mrd, input logic [DW-1:0] mdat,
                         output logic mem_acc);
        logic exp_mr, exp_ar, commit, was_empty, popped;
        ent_t c;
        @(negedge clk);
        alu_valid = av;  alu_rd = ard;  alu_data = adat;
        mem_valid = mv;  mem_rd = mrd;  mem_data = mdat;
        exp_mr = (mq.size() < DEPTH);
        exp_ar = (m_starve < LIMIT);
        #1;
        check_val("mem_ready", mem_ready, exp_mr);
        check_val("alu_ready", alu_ready, exp_ar);
        mem_acc   = mv && exp_mr;
        was_empty = (mq.size() == 0);
        popped    = 1'b0;
        commit    = 1'b0;
        c         = '{rd: '0, data: '0};
        if (m_starve >= LIMIT) begin
            c = mq.pop_front();
            commit = 1'b1;
            popped = 1'b1;
            if (mem_acc) mq.push_back('{rd: mrd, data: mdat});
        end else if (av) begin
            c = '{rd: ard, data: adat};
            commit = 1'b1;
            if (mem_acc) mq.push_back('{rd: mrd, data: mdat});
        end else if (!was_empty) begin
            c = mq.pop_front();
            commit = 1'b1;
            popped = 1'b1;
            if (mem_acc) mq.push_back('{rd: mrd, data: mdat});
        end else if (mem_acc) begin
            c = '{rd: mrd, data: mdat};
            commit = 1'b1;
        end
        if (was_empty || popped) m_starve = 0;
        else if (m_starve < LIMIT) m_starve++;
        m_we = commit && (c.rd != 0);
        if (commit) begin
            m_addr   = c.rd;
            m_data   = c.data;
            m_retire = m_retire + 64'd1;
        end
        @(posedge clk);
        #1;
        check_val("write_enable", write_enable, m_we);
        check_val("write_address", write_address, m_addr);
        check_val("write_data", write_data, m_data);
        check_val("fifo_count", fifo_count, mq.size());
        check_val("retire_count", retire_count, m_retire);
    endtask

    task automatic idle();
        logic acc;
        cycle(1'b0, '0, '0, 1'b0, '0, '0, acc);
    endtask

    logic          acc;
    logic          pend_v;
    logic [AW-1:0] pend_rd;
    logic [DW-1:0] pend_data;
    int            k;
    int            alu_pct;

    initial begin
        model_reset();
        do_reset();

        // ALU-only commit
        cycle(1'b1, 5'd1, 32'hDEADBEEF, 1'b0, '0, '0, acc);
        check_val("t1_we", write_enable, 1);
        check_val("t1_addr", write_address, 1);
        check_val("t1_data", write_data, 32'hDEADBEEF);
        check_val("t1_retire", retire_count, 1);

        // x0 write suppressed but retired
        cycle(1'b1, 5'd0, 32'h12345678, 1'b0, '0, '0, acc);
        check_val("t2_we", write_enable, 0);
        check_val("t2_retire", retire_count, 2);

        // Bypass, then ALU/MEM conflict
        cycle(1'b0, '0, '0, 1'b1, 5'd3, 32'hAAAA0003, acc);
        check_val("t3_bypass_we", write_enable, 1);
        check_val("t3_bypass_addr", write_address, 3);
        cycle(1'b1, 5'd2, 32'hAAAA0002, 1'b1, 5'd4, 32'hAAAA0004, acc);
        check_val("t3_alu_first", write_address, 2);
        check_val("t3_cnt_peak", fifo_count, 1);
        idle();
        check_val("t3_mem_next", write_address, 4);
        check_val("t3_cnt_drain", fifo_count, 0);

        // Full FIFO, backpressure and starvation forcing with ALU held busy
        k = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, AW'(16 + i), DW'(32'hB000 + i), k < 3, AW'(5 + k), DW'(32'hC000 + k), acc);
            if (acc) k++;
            if (i == 1) begin
                check_val("t4_full", fifo_count, 2);
                check_val("t4_mem_ready_lo", mem_ready, 0);
            end
            if (i == 4) check_val("t4_alu_ready_lo", alu_ready, 0);
            if (i == 5) begin
                check_val("t4_forced_addr", write_address, 5);
                check_val("t4_forced_data", write_data, 32'hC000);
                check_val("t4_alu_ready_back", alu_ready, 1);
            end
        end
        for (int i = 0; i < 3; i++) idle();
        check_val("t4_drained", fifo_count, 0);

        // Mid-operation reset drops buffered MEM results
        cycle(1'b1, 5'd1, 32'h1, 1'b1, 5'd8, 32'h8, acc);
        cycle(1'b1, 5'd1, 32'h2, 1'b1, 5'd9, 32'h9, acc);
        check_val("t5_buffered", fifo_count, 2);
        check_val("t5_we_pre", write_enable, 1);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            idle();
            check_val("t5_no_write", write_enable, 0);
        end

        // Simultaneous push and pop
        cycle(1'b1, 5'd11, 32'h11, 1'b1, 5'd12, 32'h12, acc);
        check_val("t6_hold1", fifo_count, 1);
        cycle(1'b0, '0, '0, 1'b1, 5'd13, 32'h13, acc);
        check_val("t6_head", write_address, 12);
        check_val("t6_cnt", fifo_count, 1);
        idle();
        check_val("t6_order", write_address, 13);
        check_val("t6_empty", fifo_count, 0);

        // Randomized traffic; the MEM producer holds its offer until accepted
        pend_v = 1'b0;
        pend_rd = '0;
        pend_data = '0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) alu_pct = $urandom_range(20, 100);
            if (i % 1000 == 999) begin
                do_reset();
                pend_v = 1'b0;
            end
            if (!pend_v && ($urandom % 2 == 0)) begin
                pend_v    = 1'b1;
                pend_rd   = ($urandom % 5 == 0) ? '0 : AW'($urandom);
                pend_data = $urandom;
            end
            cycle(($urandom % 100) < alu_pct,
                  ($urandom % 5 == 0) ? '0 : AW'($urandom), $urandom,
                  pend_v, pend_rd, pend_data, acc);
            if (acc) pend_v = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
